// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - funct3 codes and FSM state encoding for the memory access stage
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a loaded word
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = rdata[7:0];
      case (offset)
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         2'd3:    w_byte = rdata[31:24];
         default: w_byte = rdata[7:0];
      endcase
      // Halfword lane follows offset[1] only; an odd offset is never trapped here
      w_half = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data = rdata;
      case (funct3)
         F3_B:    data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   data = {24'd0, w_byte};
         F3_H:    data = {{16{w_half[15]}}, w_half};
         F3_HU:   data = {16'd0, w_half};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I MEM stage: dmem req/ack handshake, byte lanes, load extension
// Optional misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_in,
   input  logic              mem_write_in,
   input  logic [2:0]        mem_funct3_in,
   input  logic [31:0]       addr_in,
   input  logic [31:0]       store_data_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic [31:0]       load_data_out,
   output logic              done_out,
   output logic              stall_out,
   output logic              bus_error_out,
   output logic              misaligned_out
);

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_cnt;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_wdata;
   logic [1:0]        r_off;
   logic [2:0]        r_funct3;
   logic [31:0]       r_load;
   logic              r_done;
   logic              r_bus_err;
   logic              r_misal;

   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ext;
   logic              w_misaligned;
   logic              w_timeout;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = store_data_in;
      case (mem_funct3_in)
         F3_B, F3_BU: begin
            w_be    = 4'b0001 << addr_in[1:0];
            w_wdata = {4{store_data_in[7:0]}};
         end
         F3_H, F3_HU: begin
            w_be    = addr_in[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{store_data_in[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = store_data_in;
         end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_comb begin
      w_misaligned = 1'b0;
      case (mem_funct3_in)
         F3_B, F3_BU: w_misaligned = 1'b0;
         F3_H, F3_HU: w_misaligned = addr_in[0];
         default:     w_misaligned = (addr_in[1:0] != 2'b00);
      endcase
   end
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_timeout = (r_cnt == 8'(ACK_TIMEOUT - 1));

   load_extend u_load_extend (
      .rdata  (dmem_rdata),
      .offset (r_off),
      .funct3 (r_funct3),
      .data   (w_ext)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // DONE never issues: req_valid_in still shows the retiring op there
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req_valid_in) w_next = w_misaligned ? DONE : WAIT;
         WAIT:    if (dmem_ack || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt     <= 8'd0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_be      <= 4'd0;
         r_wdata   <= 32'd0;
         r_off     <= 2'd0;
         r_funct3  <= 3'd0;
         r_load    <= 32'd0;
         r_done    <= 1'b0;
         r_bus_err <= 1'b0;
         r_misal   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_in) begin
                  if (w_misaligned) begin
                     r_done  <= 1'b1;
                     r_misal <= 1'b1;
                     r_load  <= 32'd0;
                  end else begin
                     r_req    <= 1'b1;
                     r_we     <= mem_write_in;
                     r_addr   <= {addr_in[ADDR_W-1:2], 2'b00};
                     r_be     <= w_be;
                     r_wdata  <= w_wdata;
                     r_off    <= addr_in[1:0];
                     r_funct3 <= mem_funct3_in;
                     r_cnt    <= 8'd0;
                  end
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  r_req  <= 1'b0;
                  r_done <= 1'b1;
                  if (!r_we) r_load <= w_ext;
               end else if (w_timeout) begin
                  r_req     <= 1'b0;
                  r_load    <= 32'd0;
                  r_bus_err <= 1'b1;
                  r_done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               r_done    <= 1'b0;
               r_bus_err <= 1'b0;
               r_misal   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign stall_out      = ((r_state == IDLE) && req_valid_in) || (r_state == WAIT);
   assign dmem_req       = r_req;
   assign dmem_we        = r_we;
   assign dmem_addr      = r_addr;
   assign dmem_be        = r_be;
   assign dmem_wdata     = r_wdata;
   assign load_data_out  = r_load;
   assign done_out       = r_done;
   assign bus_error_out  = r_bus_err;
   assign misaligned_out = r_misal;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench for mem_access_stage (either MEM_MISALIGN_TRAP_EN build)
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_in;
   logic        mem_write_in;
   logic [2:0]  mem_funct3_in;
   logic [31:0] addr_in;
   logic [31:0] store_data_in;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [31:0] load_data_out;
   logic        done_out;
   logic        stall_out;
   logic        bus_error_out;
   logic        misaligned_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.ACK_TIMEOUT(16), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_in   (req_valid_in),
      .mem_write_in   (mem_write_in),
      .mem_funct3_in  (mem_funct3_in),
      .addr_in        (addr_in),
      .store_data_in  (store_data_in),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .load_data_out  (load_data_out),
      .done_out       (done_out),
      .stall_out      (stall_out),
      .bus_error_out  (bus_error_out),
      .misaligned_out (misaligned_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; req_valid_in = 1'b0; mem_write_in = 1'b0; mem_funct3_in = 3'b000;
      addr_in = 32'd0; store_data_in = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;

      // Reset state
      step(); step(); #1;
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_we", {31'd0, dmem_we}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_be", {28'd0, dmem_be}, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_load", load_data_out, 32'd0);
      chk("rst_done", {31'd0, done_out}, 32'd0);
      chk("rst_buserr", {31'd0, bus_error_out}, 32'd0);
      chk("rst_misal", {31'd0, misaligned_out}, 32'd0);
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      rst = 1'b1;

      // LB at 0x103, ack in second WAIT cycle
      step();
      req_valid_in = 1'b1; mem_write_in = 1'b0; mem_funct3_in = 3'b000;
      addr_in = 32'h0000_0103; dmem_rdata = 32'h80FF_0102; #1;
      chk("lb_stall_idle", {31'd0, stall_out}, 32'd1);
      chk("lb_req_idle", {31'd0, dmem_req}, 32'd0);
      step();
      chk("lb_req", {31'd0, dmem_req}, 32'd1);
      chk("lb_addr", dmem_addr, 32'h0000_0100);
      chk("lb_be", {28'd0, dmem_be}, 32'h8);
      chk("lb_we", {31'd0, dmem_we}, 32'd0);
      chk("lb_stall_w1", {31'd0, stall_out}, 32'd1);
      step();
      dmem_ack = 1'b1; #1;
      chk("lb_stall_w2", {31'd0, stall_out}, 32'd1);
      chk("lb_done_early", {31'd0, done_out}, 32'd0);
      step();
      dmem_ack = 1'b0; #1;
      chk("lb_done", {31'd0, done_out}, 32'd1);
      chk("lb_stall_done", {31'd0, stall_out}, 32'd0);
      chk("lb_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("lb_load", load_data_out, 32'hFFFF_FF80);
      step();
      req_valid_in = 1'b0; #1;
      chk("lb_done_pulse", {31'd0, done_out}, 32'd0);
      chk("lb_no_reissue", {31'd0, dmem_req}, 32'd0);

      // SH at 0x202, ack delayed two cycles; bus signals held
      step();
      req_valid_in = 1'b1; mem_write_in = 1'b1; mem_funct3_in = 3'b001;
      addr_in = 32'h0000_0202; store_data_in = 32'h1234_ABCD; #1;
      step();
      chk("sh_addr", dmem_addr, 32'h0000_0200);
      chk("sh_be", {28'd0, dmem_be}, 32'hC);
      chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      chk("sh_we", {31'd0, dmem_we}, 32'd1);
      addr_in = 32'h0000_0FF0; store_data_in = 32'h0; mem_funct3_in = 3'b010;
      step();
      chk("sh_hold_req", {31'd0, dmem_req}, 32'd1);
      chk("sh_hold_addr", dmem_addr, 32'h0000_0200);
      chk("sh_hold_be", {28'd0, dmem_be}, 32'hC);
      chk("sh_hold_wdata", dmem_wdata, 32'hABCD_ABCD);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0; #1;
      chk("sh_done", {31'd0, done_out}, 32'd1);
      chk("sh_load_kept", load_data_out, 32'hFFFF_FF80);
      step();
      req_valid_in = 1'b0;

      // LHU at 0x0, ack in first WAIT cycle
      step();
      req_valid_in = 1'b1; mem_write_in = 1'b0; mem_funct3_in = 3'b101;
      addr_in = 32'h0; dmem_rdata = 32'h0000_F00F;
      step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0; #1;
      chk("lhu_load", load_data_out, 32'h0000_F00F);
      chk("lhu_done", {31'd0, done_out}, 32'd1);
      step();

      // LH same data
      mem_funct3_in = 3'b001;
      step();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0; #1;
      chk("lh_load", load_data_out, 32'hFFFF_F00F);
      step();

      // SB at 0x1
      mem_write_in = 1'b1; mem_funct3_in = 3'b000; addr_in = 32'h0000_0001;
      store_data_in = 32'h5566_77EF;
      step();
      chk("sb_be", {28'd0, dmem_be}, 32'h2);
      chk("sb_wdata", dmem_wdata, 32'hEFEF_EFEF);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      step();

      // Timeout: LW with no ack for 16 WAIT cycles
      mem_write_in = 1'b0; mem_funct3_in = 3'b010; addr_in = 32'h0000_0300;
      dmem_rdata = 32'hDEAD_BEEF;
      step();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("to_req_%0d", i), {31'd0, dmem_req}, 32'd1);
         chk($sformatf("to_nodone_%0d", i), {31'd0, done_out}, 32'd0);
         step();
      end
      chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("to_buserr", {31'd0, bus_error_out}, 32'd1);
      chk("to_done", {31'd0, done_out}, 32'd1);
      chk("to_load", load_data_out, 32'd0);
      step();
      req_valid_in = 1'b0; #1;
      chk("to_buserr_pulse", {31'd0, bus_error_out}, 32'd0);

      // Reset mid-access, then late ack
      step();
      req_valid_in = 1'b1; mem_funct3_in = 3'b010; addr_in = 32'h0000_0400;
      step();
      chk("rw_req", {31'd0, dmem_req}, 32'd1);
      rst = 1'b0; req_valid_in = 1'b0;
      step();
      chk("rw_req_drop", {31'd0, dmem_req}, 32'd0);
      rst = 1'b1;
      step();
      dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      step();
      dmem_ack = 1'b0; #1;
      chk("rw_req_idle", {31'd0, dmem_req}, 32'd0);
      chk("rw_done", {31'd0, done_out}, 32'd0);
      chk("rw_load", load_data_out, 32'd0);
      chk("rw_addr", dmem_addr, 32'd0);
      chk("rw_be", {28'd0, dmem_be}, 32'd0);
      chk("rw_stall", {31'd0, stall_out}, 32'd0);

      // LW at 0x102
      req_valid_in = 1'b1; mem_write_in = 1'b0; mem_funct3_in = 3'b010;
      addr_in = 32'h0000_0102; #1;
      chk("mis_stall_idle", {31'd0, stall_out}, 32'd1);
      step();
`ifdef MEM_MISALIGN_TRAP_EN
      chk("mis_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_flag", {31'd0, misaligned_out}, 32'd1);
      chk("mis_done", {31'd0, done_out}, 32'd1);
      chk("mis_stall", {31'd0, stall_out}, 32'd0);
      chk("mis_load", load_data_out, 32'd0);
      step();
      req_valid_in = 1'b0; #1;
      chk("mis_flag_pulse", {31'd0, misaligned_out}, 32'd0);
`else
      chk("mis_req", {31'd0, dmem_req}, 32'd1);
      chk("mis_addr", dmem_addr, 32'h0000_0100);
      chk("mis_be", {28'd0, dmem_be}, 32'hF);
      chk("mis_flag", {31'd0, misaligned_out}, 32'd0);
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0; #1;
      chk("mis_done", {31'd0, done_out}, 32'd1);
      chk("mis_load", load_data_out, 32'h1234_5678);
      step();
      req_valid_in = 1'b0;
`endif
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
